// File: rtl/eggtimer_pkg.sv
// rtl/eggtimer_pkg.sv - state encoding and defaults for the egg timer control FSM
package eggtimer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_ALARM = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        RUN   = ST_RUN,
        PAUSE = ST_PAUSE,
        ALARM = ST_ALARM
    } state_t;

    localparam int DEFAULT_ALARM_SECS      = 10;
    localparam int DEFAULT_ALARM_CTR_WIDTH = 4;

endpackage

// File: rtl/eggtimer_ctrl_edge_detect.sv
// rtl/eggtimer_ctrl_edge_detect.sv - registered rising-edge detector for a debounced button level
module edge_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic prev;

    // Resetting prev high suppresses an edge for a button held through reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= RESET_VAL;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/eggtimer_ctrl.sv
// rtl/eggtimer_ctrl.sv - egg timer control FSM: run, pause, alarm and re-arm of the digit counters
module eggtimer_ctrl
    import eggtimer_pkg::*;
#(
    parameter int ALARM_SECS      = DEFAULT_ALARM_SECS,
    parameter int ALARM_CTR_WIDTH = DEFAULT_ALARM_CTR_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic start_stop,
    input  logic clear,
    input  logic tick,
    input  logic count_zero,
    output logic load,
    output logic count_enable,
    output logic running,
    output logic alarm,
    output logic done
);

    localparam logic [ALARM_CTR_WIDTH-1:0] ALARM_LAST = ALARM_CTR_WIDTH'(ALARM_SECS - 1);

    state_t                     state;
    state_t                     next_state;
    logic                       ss_edge;
    logic                       clr_edge;
    logic [ALARM_CTR_WIDTH-1:0] alarm_ctr;
    logic                       blink;
    logic                       done_q;

    edge_detect #(.RESET_VAL(1'b1)) u_ss_edge (
        .clk   (clk),
        .reset (reset),
        .level (start_stop),
        .rise  (ss_edge)
    );

    edge_detect #(.RESET_VAL(1'b1)) u_clr_edge (
        .clk   (clk),
        .reset (reset),
        .level (clear),
        .rise  (clr_edge)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        load         = 1'b0;
        count_enable = 1'b0;
        running      = 1'b0;
        alarm        = 1'b0;
        case (state)
            IDLE: begin
                load = 1'b1;
                // A simultaneous clear edge outranks start.
                if (!clr_edge && ss_edge) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                running      = 1'b1;
                count_enable = tick & ~count_zero;
                if (clr_edge) begin
                    next_state = IDLE;
                end else if (ss_edge) begin
                    next_state = PAUSE;
                end else if (count_zero) begin
                    next_state = ALARM;
                end
            end
            PAUSE: begin
                if (clr_edge) begin
                    next_state = IDLE;
                end else if (ss_edge) begin
                    next_state = RUN;
                end
            end
            ALARM: begin
                alarm = blink;
                if (clr_edge || ss_edge) begin
                    next_state = IDLE;
                end else if (tick && (alarm_ctr == ALARM_LAST)) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Alarm duration and blink phase restart on every entry and are held cleared elsewhere.
    always_ff @(posedge clk) begin
        if (reset) begin
            alarm_ctr <= '0;
            blink     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state == RUN) && (next_state == ALARM);
            if ((state != ALARM) && (next_state == ALARM)) begin
                alarm_ctr <= '0;
                blink     <= 1'b1;
            end else if ((state == ALARM) && (next_state == ALARM)) begin
                if (tick) begin
                    alarm_ctr <= alarm_ctr + 1'b1;
                    blink     <= ~blink;
                end
            end else begin
                alarm_ctr <= '0;
                blink     <= 1'b0;
            end
        end
    end

    assign done = done_q;

endmodule

// File: doc/eggtimer_ctrl.md
Name: eggtimer_ctrl

Overview:
Control FSM directly downstream of the 1 s clock_divider and the digit_counter chain. It consumes the 1 s tick and the counters' all-zero flag, and takes two debounced user buttons. It produces the counters' load and count-enable, plus the run/alarm indications that drive the display and buzzer. It decides when the egg timer runs, pauses, alarms and re-arms.

Parameters:
ALARM_SECS, 10, number of tick pulses the alarm sounds before auto-return to IDLE (1..2^ALARM_CTR_WIDTH-1)
ALARM_CTR_WIDTH, 4, width of the alarm-duration counter

Ports:
clk  input  1  system clock, single clock domain
reset  input  1  synchronous, active-high reset
start_stop  input  1  debounced level of start/pause button
clear  input  1  debounced level of clear button
tick  input  1  one-cycle 1 s pulse from clock_divider
count_zero  input  1  high when all digit_counters read zero (AND of term_count)
load  output  1  high: digit_counters hold/reload programmed start value (drives their reset)
count_enable  output  1  one-cycle enable to the least-significant digit_counter
running  output  1  high in RUN
alarm  output  1  buzzer/LED drive, blinks in ALARM
done  output  1  one-cycle pulse on RUN->ALARM transition

Behaviour:
- One clock, synchronous active-high reset; all state updates on posedge clk.
- Button edge detect: rising edge = level & ~prev. Prev registers reset to 1, so a button held through reset produces no edge until it is released and pressed again.
- States: IDLE, RUN, PAUSE, ALARM. Reset -> IDLE.
- Reset values: load=1, count_enable=0, running=0, alarm=0, done=0, alarm counter=0, blink=0.
- Outputs:
  - load = (state==IDLE), combinational from state.
  - count_enable = (state==RUN) & tick & ~count_zero, combinational.
  - running = (state==RUN).
  - alarm = (state==ALARM) & blink.
- Priority each cycle: clear_edge > start_stop_edge > count_zero/tick.
- IDLE:
  - start_stop_edge -> RUN.
  - count_enable is 0 in the same cycle; load drops the next cycle.
- RUN:
  - clear_edge -> IDLE.
  - Else start_stop_edge -> PAUSE.
  - Else count_zero -> ALARM, with done=1 for exactly that transition cycle (registered, asserted the cycle after the transition is decided).
- PAUSE:
  - clear_edge -> IDLE.
  - start_stop_edge -> RUN.
  - Ticks are ignored; counters hold.
- ALARM:
  - On entry: blink=1, alarm counter=0.
  - Each tick toggles blink and increments the counter.
  - When counter==ALARM_SECS-1 and tick -> IDLE.
  - Any button edge (clear or start_stop) -> IDLE immediately (acknowledge).
- Tick in the same cycle as a start_stop_edge in RUN: count_enable is still asserted that cycle (state still RUN), so the decrement is taken, then PAUSE.
- Programmed value zero: IDLE->RUN, then on the first RUN cycle count_zero=1 -> ALARM. No count_enable is ever issued.
- count_zero is ignored outside RUN.
- Alarm counter saturates logic: it only counts in ALARM, is cleared on every entry to ALARM, and never wraps.
- reset mid-operation: returns to IDLE in the next cycle, load=1, alarm=0; any in-progress alarm is dropped.
- Illegal state encoding -> IDLE.

Decomposition:
- Package eggtimer_pkg: state encoding localparams (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, ALARM=2'd3) and the default ALARM_SECS.
- One sub-module: edge_detect (registered rising-edge detector with reset value parameter), instantiated twice, for start_stop and clear.

Test Plan:
- Reset with start_stop held high, release then press -> no edge during hold; after press, running=1 next cycle and load=0.
- Counters programmed to 9, tick every 10 clk, start -> count_enable pulses 9 times; count_zero rises, then done=1 for one cycle, alarm toggles on subsequent ticks; after 10 ticks state IDLE, load=1, alarm=0.
- Start, then pause after 3 ticks, wait 5 ticks, resume -> exactly 3 count_enable pulses before pause, 0 during pause, counting continues after resume; zero reached after 9 total enables.
- start_stop edge coincident with tick in RUN -> count_enable=1 that cycle, state PAUSE next cycle; clear and start_stop edges in the same cycle in RUN -> IDLE, not PAUSE.
- Programmed value 0, press start -> RUN for 1 cycle, then ALARM with done pulse, no count_enable.
- In ALARM after 2 ticks, press clear -> IDLE next cycle, alarm=0; assert reset mid-RUN -> IDLE, load=1, all other outputs 0 the following cycle.
